// File: rtl/mux41_case.sv
// rtl/mux41_case.sv - registered 4:1 datapath selector with registered select echo
module mux41_case #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d_0,
  input  logic [WIDTH-1:0] i_d_1,
  input  logic [WIDTH-1:0] i_d_2,
  input  logic [WIDTH-1:0] i_d_3,
  input  logic [1:0]       i_sel,
  output logic [WIDTH-1:0] o_y,
  output logic [1:0]       o_sel
);

  logic [WIDTH-1:0] sel_data;

  // Select stage; an unknown select in simulation falls back to input 0.
  always_comb begin
    sel_data = i_d_0;
    case (i_sel)
      2'd0:    sel_data = i_d_0;
      2'd1:    sel_data = i_d_1;
      2'd2:    sel_data = i_d_2;
      2'd3:    sel_data = i_d_3;
      default: sel_data = i_d_0;
    endcase
  end

  // Output register loads every cycle; reset forces the reset value and select 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_y   <= RESET_VALUE;
      o_sel <= 2'd0;
    end else begin
      o_y   <= sel_data;
      o_sel <= i_sel;
    end
  end

endmodule

// File: tb/tb_mux41_case.sv
// tb/tb_mux41_case.sv - directed self-checking bench for mux41_case
module tb_mux41_case;

  logic       clk;
  logic       reset;
  logic [7:0] d0, d1, d2, d3;
  logic [1:0] sel;
  logic [7:0] y;
  logic [1:0] y_sel;

  int vectors;
  int miscompares;

  mux41_case #(
    .WIDTH(8),
    .RESET_VALUE(8'h00)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .i_d_0  (d0),
    .i_d_1  (d1),
    .i_d_2  (d2),
    .i_d_3  (d3),
    .i_sel  (sel),
    .o_y    (y),
    .o_sel  (y_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    d0 = 8'd0; d1 = 8'd1; d2 = 8'd2; d3 = 8'd3;
    sel = 2'd2;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (y !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_y cycle %0d: got %h expected %h", i, y, 8'd0);
      end
      vectors++;
      if (y_sel !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_sel cycle %0d: got %0d expected %0d", i, y_sel, 0);
      end
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (y !== 8'd2) begin
      miscompares++;
      $display("FAIL reset_release_y: got %h expected %h", y, 8'd2);
    end
    vectors++;
    if (y_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL reset_release_sel: got %0d expected %0d", y_sel, 2);
    end
  endtask

  task automatic test_select_sweep();
    logic [7:0] base;
    logic [7:0] exp_y;
    for (int b = 0; b < 3; b++) begin
      base = 8'(b * 4);
      d0 = base; d1 = base + 8'd1; d2 = base + 8'd2; d3 = base + 8'd3;
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        exp_y = base + 8'(s);
        tick();
        vectors++;
        if (y !== exp_y) begin
          miscompares++;
          $display("FAIL sweep_y base %0d sel %0d: got %h expected %h", base, s, y, exp_y);
        end
        vectors++;
        if (y_sel !== 2'(s)) begin
          miscompares++;
          $display("FAIL sweep_sel base %0d: got %0d expected %0d", base, y_sel, s);
        end
      end
    end
  endtask

  task automatic test_data_change();
    sel = 2'd1;
    d1 = 8'd5;
    tick();
    vectors++;
    if (y !== 8'd5) begin
      miscompares++;
      $display("FAIL data_change_first: got %h expected %h", y, 8'd5);
    end
    d1 = 8'd9;
    tick();
    vectors++;
    if (y !== 8'd9) begin
      miscompares++;
      $display("FAIL data_change_second: got %h expected %h", y, 8'd9);
    end
    d0 = 8'hA5; d2 = 8'h5A; d3 = 8'hC3;
    tick();
    vectors++;
    if (y !== 8'd9) begin
      miscompares++;
      $display("FAIL data_change_unselected: got %h expected %h", y, 8'd9);
    end
  endtask

  task automatic test_simultaneous();
    d0 = 8'h20;
    d3 = 8'd7;
    sel = 2'd0;
    tick();
    vectors++;
    if (y !== 8'h20) begin
      miscompares++;
      $display("FAIL simul_before: got %h expected %h", y, 8'h20);
    end
    sel = 2'd3;
    d3 = 8'd11;
    tick();
    vectors++;
    if (y !== 8'd11) begin
      miscompares++;
      $display("FAIL simul_change_y: got %h expected %h", y, 8'd11);
    end
    vectors++;
    if (y_sel !== 2'd3) begin
      miscompares++;
      $display("FAIL simul_change_sel: got %0d expected %0d", y_sel, 3);
    end
  endtask

  task automatic test_width_boundary();
    d0 = 8'h00; d1 = 8'h00; d2 = 8'hFF; d3 = 8'h00;
    sel = 2'd2;
    tick();
    vectors++;
    if (y !== 8'hFF) begin
      miscompares++;
      $display("FAIL width_all_ones: got %h expected %h", y, 8'hFF);
    end
    sel = 2'd3;
    tick();
    vectors++;
    if (y !== 8'h00) begin
      miscompares++;
      $display("FAIL width_all_zeros: got %h expected %h", y, 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    d0 = 8'h10; d1 = 8'h11; d2 = 8'h12; d3 = 8'h13;
    sel = 2'd1;
    tick();
    vectors++;
    if (y !== 8'h11) begin
      miscompares++;
      $display("FAIL mid_before: got %h expected %h", y, 8'h11);
    end
    // A reset pulse that falls between edges must be ignored.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    sel = 2'd2;
    tick();
    vectors++;
    if (y !== 8'h12) begin
      miscompares++;
      $display("FAIL mid_glitch_ignored: got %h expected %h", y, 8'h12);
    end
    reset = 1'b1;
    sel = 2'd3;
    tick();
    vectors++;
    if (y !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_y: got %h expected %h", y, 8'h00);
    end
    vectors++;
    if (y_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_reset_sel: got %0d expected %0d", y_sel, 0);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (y !== 8'h13) begin
      miscompares++;
      $display("FAIL mid_resume_y: got %h expected %h", y, 8'h13);
    end
    vectors++;
    if (y_sel !== 2'd3) begin
      miscompares++;
      $display("FAIL mid_resume_sel: got %0d expected %0d", y_sel, 3);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    sel = 2'd0;
    #1;
    test_reset();
    test_select_sweep();
    test_data_change();
    test_simultaneous();
    test_width_boundary();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
